// File: rtl/shadow_ret_stack.sv
// Shadow return-address stack: keyed entries pushed on calls, checked on returns.
// Overflow either drops the oldest entry (LOST) or crashes, depending on OVF_CRASH.
module shadow_ret_stack #(
  parameter int           VLEN      = 32,
  parameter int           DEPTH     = 8,
  parameter logic [31:0]  KEY       = 32'h73fa06c2,
  parameter bit           OVF_CRASH = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       call_valid_i,
  input  logic [VLEN-1:0]            call_ret_addr_i,
  input  logic                       ret_valid_i,
  input  logic [VLEN-1:0]            ret_target_i,
  input  logic                       crash_ack_i,
  output logic                       crash_o,
  output logic                       ovf_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic [15:0]                mismatch_cnt_o,
  output logic [1:0]                 state_o
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [VLEN-1:0] KEY_V = VLEN'(KEY);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LOST  = 2'd1,
    S_CRASH = 2'd2
  } state_t;

  logic [VLEN-1:0] r_mem [DEPTH];
  state_t          r_state;
  logic            r_crash;
  logic            r_ovf;
  logic [DW-1:0]   r_depth;
  logic [15:0]     r_cnt;

  logic            w_empty;
  logic            w_full;
  logic [PW-1:0]   w_top_idx;
  logic [VLEN-1:0] w_top;
  logic            w_act;
  logic            w_push;
  logic            w_pop;
  logic            w_miss;
  logic            w_pop_ok;
  logic            w_push_ok;
  logic            w_replace;
  logic            w_push_only;
  logic            w_wr;
  logic            w_shift;
  logic [PW-1:0]   w_widx;

  assign w_empty   = (r_depth == '0);
  assign w_full    = (r_depth == DW'(DEPTH));
  assign w_top_idx = PW'(r_depth - DW'(1));
  assign w_top     = r_mem[w_top_idx] ^ KEY_V;

  // Pop is evaluated before push; a failed check cancels the push of the same cycle.
  always_comb begin
    w_act       = en_i & ~flush_i & (r_state != S_CRASH);
    w_push      = w_act & call_valid_i;
    w_pop       = w_act & ret_valid_i;
    w_miss      = w_pop & (w_empty ? (r_state == S_RUN) : (ret_target_i != w_top));
    w_pop_ok    = w_pop & ~w_empty & ~w_miss;
    w_push_ok   = w_push & ~w_miss;
    w_replace   = w_pop_ok & w_push_ok;
    w_push_only = w_push_ok & ~w_pop_ok;
    w_wr        = w_replace | (w_push_only & (~w_full | ~OVF_CRASH));
    w_shift     = w_push_only & w_full & ~OVF_CRASH;
    w_widx      = (w_replace | w_full) ? w_top_idx : r_depth[PW-1:0];
  end

  // Entry 0 is always the oldest, so dropping it is a one-place shift down.
  always_ff @(posedge clk_i) begin
    if (w_shift) begin
      for (int i = 0; i < DEPTH-1; i++) r_mem[i] <= r_mem[i+1];
    end
    if (w_wr) r_mem[w_widx] <= call_ret_addr_i ^ KEY_V;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_RUN;
      r_crash <= 1'b0;
      r_ovf   <= 1'b0;
      r_depth <= '0;
      r_cnt   <= '0;
    end else if (flush_i) begin
      r_state <= S_RUN;
      r_crash <= 1'b0;
      r_ovf   <= 1'b0;
      r_depth <= '0;
    end else if (r_state == S_CRASH) begin
      if (crash_ack_i) begin
        r_state <= S_RUN;
        r_crash <= 1'b0;
        r_depth <= '0;
      end
    end else if (w_miss) begin
      r_state <= S_CRASH;
      r_crash <= 1'b1;
      if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end else if (w_pop_ok && !w_push_ok) begin
      r_depth <= r_depth - DW'(1);
    end else if (w_push_only) begin
      if (!w_full) begin
        r_depth <= r_depth + DW'(1);
      end else if (OVF_CRASH) begin
        r_state <= S_CRASH;
        r_crash <= 1'b1;
        r_ovf   <= 1'b1;
      end else begin
        r_state <= S_LOST;
        r_ovf   <= 1'b1;
      end
    end
  end

  assign crash_o        = r_crash;
  assign ovf_o          = r_ovf;
  assign depth_o        = r_depth;
  assign mismatch_cnt_o = r_cnt;
  assign state_o        = r_state;

endmodule

// File: tb/tb_shadow_ret_stack.sv
// Bench for shadow_ret_stack: two DEPTH=4 instances (drop-oldest and crash overflow)
// driven in lockstep; a monitor compares every cycle against queued expected values.
module tb_shadow_ret_stack;

  localparam int VLEN = 32;
  localparam int EW   = 23;
  localparam logic [1:0] RUN = 2'd0, LOST = 2'd1, CRASH = 2'd2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en, flush, call_v, ret_v, ack;
  logic [VLEN-1:0] call_a, ret_a;

  logic            a_crash, a_ovf, b_crash, b_ovf;
  logic [2:0]      a_depth, b_depth;
  logic [15:0]     a_cnt, b_cnt;
  logic [1:0]      a_state, b_state;

  logic [EW-1:0]   exp_a_q[$];
  logic [EW-1:0]   exp_b_q[$];
  int              id_q[$];
  int              n_checks = 0;
  int              n_errors = 0;

  always #5 clk = ~clk;

  shadow_ret_stack #(.VLEN(VLEN), .DEPTH(4), .OVF_CRASH(1'b0)) u_drop (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush),
    .call_valid_i(call_v), .call_ret_addr_i(call_a),
    .ret_valid_i(ret_v), .ret_target_i(ret_a), .crash_ack_i(ack),
    .crash_o(a_crash), .ovf_o(a_ovf), .depth_o(a_depth),
    .mismatch_cnt_o(a_cnt), .state_o(a_state)
  );

  shadow_ret_stack #(.VLEN(VLEN), .DEPTH(4), .OVF_CRASH(1'b1)) u_crash (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush),
    .call_valid_i(call_v), .call_ret_addr_i(call_a),
    .ret_valid_i(ret_v), .ret_target_i(ret_a), .crash_ack_i(ack),
    .crash_o(b_crash), .ovf_o(b_ovf), .depth_o(b_depth),
    .mismatch_cnt_o(b_cnt), .state_o(b_state)
  );

  function automatic logic [EW-1:0] mk(input logic [1:0] st, input logic cr, input logic ov,
                                       input logic [2:0] dp, input logic [15:0] cnt);
    return {st, cr, ov, dp, cnt};
  endfunction

  task automatic compare(input string name, input int id, input logic [EW-1:0] got,
                         input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got st=%0d crash=%0b ovf=%0b depth=%0d cnt=%0d, expected st=%0d crash=%0b ovf=%0b depth=%0d cnt=%0d",
               name, id, got[22:21], got[20], got[19], got[18:16], got[15:0],
               exp[22:21], exp[20], exp[19], exp[18:16], exp[15:0]);
    end
  endtask

  // Monitor: one expected entry per driven cycle, checked just after the edge that applies it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_a_q.size() > 0) begin
        int id;
        id = id_q.pop_front();
        compare("drop", id, {a_state, a_crash, a_ovf, a_depth, a_cnt}, exp_a_q.pop_front());
        compare("crash", id, {b_state, b_crash, b_ovf, b_depth, b_cnt}, exp_b_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    en = 1'b1; flush = 1'b0; call_v = 1'b0; ret_v = 1'b0; ack = 1'b0;
    call_a = '0; ret_a = '0;
  endtask

  task automatic step(input int id, input logic fl, input logic e, input logic cv,
                      input logic [VLEN-1:0] ca, input logic rv, input logic [VLEN-1:0] ra,
                      input logic ak, input logic [EW-1:0] ea, input logic [EW-1:0] eb);
    @(posedge clk);
    #2;
    flush = fl; en = e; call_v = cv; call_a = ca; ret_v = rv; ret_a = ra; ack = ak;
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    id_q.push_back(id);
  endtask

  task automatic check_zero(input int id);
    compare("drop_reset", id, {a_state, a_crash, a_ovf, a_depth, a_cnt}, mk(RUN, 0, 0, 0, 0));
    compare("crash_reset", id, {b_state, b_crash, b_ovf, b_depth, b_cnt}, mk(RUN, 0, 0, 0, 0));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [EW-1:0] b_ovc;
    idle_inputs();
    #1;
    check_zero(0);
    #22;
    rst_n = 1'b1;

    // Matching call/return
    step(1, 0, 1, 1, 32'h80000104, 0, 0, 0, mk(RUN, 0, 0, 1, 0), mk(RUN, 0, 0, 1, 0));
    step(2, 0, 1, 0, 0, 1, 32'h80000104, 0, mk(RUN, 0, 0, 0, 0), mk(RUN, 0, 0, 0, 0));
    // Mismatching return, crash held, then acknowledged
    step(3, 0, 1, 1, 32'h80000104, 0, 0, 0, mk(RUN, 0, 0, 1, 0), mk(RUN, 0, 0, 1, 0));
    step(4, 0, 1, 0, 0, 1, 32'h80000200, 0, mk(CRASH, 1, 0, 1, 1), mk(CRASH, 1, 0, 1, 1));
    step(5, 0, 1, 0, 0, 0, 0, 0, mk(CRASH, 1, 0, 1, 1), mk(CRASH, 1, 0, 1, 1));
    step(6, 0, 1, 0, 0, 0, 0, 1, mk(RUN, 0, 0, 0, 1), mk(RUN, 0, 0, 0, 1));
    // Disabled: call ignored
    step(7, 0, 0, 1, 32'h00000777, 0, 0, 0, mk(RUN, 0, 0, 0, 1), mk(RUN, 0, 0, 0, 1));
    // Fill to four, then overflow
    step(8,  0, 1, 1, 32'h00001000, 0, 0, 0, mk(RUN, 0, 0, 1, 1), mk(RUN, 0, 0, 1, 1));
    step(9,  0, 1, 1, 32'h00002000, 0, 0, 0, mk(RUN, 0, 0, 2, 1), mk(RUN, 0, 0, 2, 1));
    step(10, 0, 1, 1, 32'h00003000, 0, 0, 0, mk(RUN, 0, 0, 3, 1), mk(RUN, 0, 0, 3, 1));
    step(11, 0, 1, 1, 32'h00004000, 0, 0, 0, mk(RUN, 0, 0, 4, 1), mk(RUN, 0, 0, 4, 1));
    b_ovc = mk(CRASH, 1, 1, 4, 1);
    step(12, 0, 1, 1, 32'h00005000, 0, 0, 0, mk(LOST, 0, 1, 4, 1), b_ovc);
    // Returns A5..A2 pass, fifth return on empty LOST stack is unchecked
    step(13, 0, 1, 0, 0, 1, 32'h00005000, 0, mk(LOST, 0, 1, 3, 1), b_ovc);
    step(14, 0, 1, 0, 0, 1, 32'h00004000, 0, mk(LOST, 0, 1, 2, 1), b_ovc);
    step(15, 0, 1, 0, 0, 1, 32'h00003000, 0, mk(LOST, 0, 1, 1, 1), b_ovc);
    step(16, 0, 1, 0, 0, 1, 32'h00002000, 0, mk(LOST, 0, 1, 0, 1), b_ovc);
    step(17, 0, 1, 0, 0, 1, 32'h00001000, 0, mk(LOST, 0, 1, 0, 1), b_ovc);
    // Same-cycle return and call replace the top
    step(18, 0, 1, 1, 32'h80000104, 0, 0, 0, mk(LOST, 0, 1, 1, 1), b_ovc);
    step(19, 0, 1, 1, 32'h80000300, 1, 32'h80000104, 0, mk(LOST, 0, 1, 1, 1), b_ovc);
    step(20, 0, 1, 0, 0, 1, 32'h80000300, 0, mk(LOST, 0, 1, 0, 1), b_ovc);
    // Same-cycle on empty LOST stack: push alone
    step(21, 0, 1, 1, 32'h00007000, 1, 32'h00001234, 0, mk(LOST, 0, 1, 1, 1), b_ovc);
    step(22, 0, 1, 0, 0, 1, 32'h00007000, 0, mk(LOST, 0, 1, 0, 1), b_ovc);
    // Flush wins over a concurrent call and keeps the counter
    step(23, 1, 1, 1, 32'h00000abc, 0, 0, 0, mk(RUN, 0, 0, 0, 1), mk(RUN, 0, 0, 0, 1));
    step(24, 0, 1, 1, 32'h00008000, 0, 0, 1, mk(RUN, 0, 0, 1, 1), mk(RUN, 0, 0, 1, 1));
    // Mismatch discards the concurrent push
    step(25, 0, 1, 1, 32'h0000a000, 1, 32'h00009000, 0, mk(CRASH, 1, 0, 1, 2), mk(CRASH, 1, 0, 1, 2));
    // Ack wins over a concurrent call
    step(26, 0, 1, 1, 32'h0000b000, 0, 0, 1, mk(RUN, 0, 0, 0, 2), mk(RUN, 0, 0, 0, 2));
    // Return on empty stack in RUN is a mismatch
    step(27, 0, 1, 0, 0, 1, 32'h00000044, 0, mk(CRASH, 1, 0, 0, 3), mk(CRASH, 1, 0, 0, 3));
    step(28, 0, 1, 0, 0, 0, 0, 1, mk(RUN, 0, 0, 0, 3), mk(RUN, 0, 0, 0, 3));
    // Build depth 3 and crash before a mid-sequence reset
    step(29, 0, 1, 1, 32'h00000001, 0, 0, 0, mk(RUN, 0, 0, 1, 3), mk(RUN, 0, 0, 1, 3));
    step(30, 0, 1, 1, 32'h00000002, 0, 0, 0, mk(RUN, 0, 0, 2, 3), mk(RUN, 0, 0, 2, 3));
    step(31, 0, 1, 1, 32'h00000003, 0, 0, 0, mk(RUN, 0, 0, 3, 3), mk(RUN, 0, 0, 3, 3));
    step(32, 0, 1, 0, 0, 1, 32'h00000005, 0, mk(CRASH, 1, 0, 3, 4), mk(CRASH, 1, 0, 3, 4));

    @(posedge clk);
    #3;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_zero(100);
    #13;
    rst_n = 1'b1;
    step(33, 0, 1, 0, 0, 1, 32'h00000044, 0, mk(CRASH, 1, 0, 0, 1), mk(CRASH, 1, 0, 0, 1));

    @(posedge clk);
    #2;
    idle_inputs();
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (exp_a_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_a_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
